// File: rtl/ram_arbiter_rr.sv
// N-port arbiter in front of a single-port, byte-lane-writable synchronous RAM.
// Fixed-priority or round-robin grant, one access per cycle, per-port held read data.
module ram_arbiter_rr #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned RAM_DEPTH = 32,
    parameter int unsigned PRIO_MODE = 1
) (
    input  logic                          CLK,
    input  logic                          RSTb,
    input  logic [NUM_PORTS-1:0]          REQ,
    input  logic [NUM_PORTS-1:0]          WE,
    input  logic [NUM_PORTS*ADDR_W-1:0]   ADDR,
    input  logic [NUM_PORTS*DATA_W-1:0]   WDATA,
    input  logic [NUM_PORTS*DATA_W/8-1:0] BE,
    output logic [NUM_PORTS-1:0]          GNT,
    output logic [NUM_PORTS-1:0]          RVALID,
    output logic [NUM_PORTS*DATA_W-1:0]   RDATA,
    output logic [NUM_PORTS-1:0]          ERR,
    output logic                          RAM_CSb,
    output logic [DATA_W/8-1:0]           RAM_WEb,
    output logic [$clog2(RAM_DEPTH)-1:0]  RAM_ADDR,
    output logic [DATA_W-1:0]             RAM_WDATA,
    input  logic [DATA_W-1:0]             RAM_RDATA
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned BW    = $clog2(BE_W);
    localparam int unsigned PTR_W = $clog2(NUM_PORTS);
    localparam int unsigned RA_W  = $clog2(RAM_DEPTH);
    localparam int unsigned WI_W  = ADDR_W - BW;

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]  gnt_idx;
    logic              gnt_any;
    logic              sel_we;
    logic [WI_W-1:0]   word_idx;
    logic [BE_W-1:0]   sel_be;
    logic              in_range;
    logic              ram_acc;

    logic              rv_q, er_q, oor_q;
    logic [PTR_W-1:0]  port_q;
    logic [DATA_W-1:0] hold_q [NUM_PORTS];
    logic [DATA_W-1:0] rd_val;

    // Search starts at rr_ptr in round-robin mode, at port 0 otherwise.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            int unsigned p;
            p = k;
            if (PRIO_MODE != 0) begin
                p = 32'(rr_ptr_q) + k;
                if (p >= NUM_PORTS) p = p - NUM_PORTS;
            end
            if (!gnt_any && REQ[p]) begin
                gnt_any = 1'b1;
                gnt_idx = PTR_W'(p);
            end
        end
    end

    always_comb begin
        GNT = '0;
        if (gnt_any) GNT[gnt_idx] = 1'b1;
    end

    assign sel_we   = WE[gnt_idx];
    assign word_idx = ADDR[gnt_idx*ADDR_W + BW +: WI_W];
    assign sel_be   = BE[gnt_idx*BE_W +: BE_W];
    assign in_range = 32'(word_idx) < RAM_DEPTH;
    // The RAM is never driven while reset is held, even though GNT still follows REQ.
    assign ram_acc  = gnt_any & in_range & RSTb;

    assign RAM_CSb   = ~ram_acc;
    assign RAM_WEb   = ~({BE_W{ram_acc & sel_we}} & sel_be);
    assign RAM_ADDR  = RA_W'(word_idx);
    assign RAM_WDATA = WDATA[gnt_idx*DATA_W +: DATA_W];

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_any) begin
            if (32'(gnt_idx) == NUM_PORTS - 1) rr_ptr_d = '0;
            else                               rr_ptr_d = gnt_idx + 1'b1;
        end
    end

    assign rd_val = oor_q ? '0 : RAM_RDATA;

    always_comb begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            RVALID[p] = rv_q && (32'(port_q) == p);
            ERR[p]    = er_q && (32'(port_q) == p);
            RDATA[p*DATA_W +: DATA_W] = RVALID[p] ? rd_val : hold_q[p];
        end
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            rr_ptr_q <= '0;
            rv_q     <= 1'b0;
            er_q     <= 1'b0;
            oor_q    <= 1'b0;
            port_q   <= '0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) hold_q[p] <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            rv_q     <= gnt_any & ~sel_we;
            er_q     <= gnt_any & ~in_range;
            oor_q    <= ~in_range;
            port_q   <= gnt_idx;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (RVALID[p]) hold_q[p] <= rd_val;
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter_rr.sv
// Bench for ram_arbiter_rr: round-robin instance with a RAM fixture, plus a
// fixed-priority instance for grant checks, compared against a behavioural model.
module tb_ram_arbiter_rr;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int DEPTH = 32;

    logic CLK = 1'b0;
    logic RSTb = 1'b0;
    always #5 CLK = ~CLK;

    logic [NP-1:0]    REQ, WE;
    logic [NP*AW-1:0] ADDR;
    logic [NP*DW-1:0] WDATA;
    logic [NP*4-1:0]  BE;

    logic [NP-1:0]    GNT, RVALID, ERR;
    logic [NP*DW-1:0] RDATA;
    logic             RAM_CSb;
    logic [3:0]       RAM_WEb;
    logic [4:0]       RAM_ADDR;
    logic [DW-1:0]    RAM_WDATA, RAM_RDATA;

    logic [NP-1:0]    f_gnt, f_rvalid, f_err;
    logic [NP*DW-1:0] f_rdata;
    logic             f_csb;
    logic [3:0]       f_web;
    logic [4:0]       f_addr;
    logic [DW-1:0]    f_wdata;
    logic [DW-1:0]    f_ram_rdata;
    assign f_ram_rdata = '0;

    ram_arbiter_rr #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .RAM_DEPTH(DEPTH),
                     .PRIO_MODE(1)) dut (
        .CLK(CLK), .RSTb(RSTb), .REQ(REQ), .WE(WE), .ADDR(ADDR), .WDATA(WDATA), .BE(BE),
        .GNT(GNT), .RVALID(RVALID), .RDATA(RDATA), .ERR(ERR), .RAM_CSb(RAM_CSb),
        .RAM_WEb(RAM_WEb), .RAM_ADDR(RAM_ADDR), .RAM_WDATA(RAM_WDATA), .RAM_RDATA(RAM_RDATA)
    );

    ram_arbiter_rr #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .RAM_DEPTH(DEPTH),
                     .PRIO_MODE(0)) dut_fix (
        .CLK(CLK), .RSTb(RSTb), .REQ(REQ), .WE(WE), .ADDR(ADDR), .WDATA(WDATA), .BE(BE),
        .GNT(f_gnt), .RVALID(f_rvalid), .RDATA(f_rdata), .ERR(f_err), .RAM_CSb(f_csb),
        .RAM_WEb(f_web), .RAM_ADDR(f_addr), .RAM_WDATA(f_wdata), .RAM_RDATA(f_ram_rdata)
    );

    // RAM fixture driven only by the DUT pins.
    logic [DW-1:0] ram [DEPTH];
    logic          ram_clear;
    always @(posedge CLK) begin
        if (ram_clear) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
            RAM_RDATA <= '0;
        end else if (!RAM_CSb) begin
            for (int b = 0; b < 4; b++)
                if (!RAM_WEb[b]) ram[RAM_ADDR][b*8 +: 8] <= RAM_WDATA[b*8 +: 8];
            RAM_RDATA <= ram[RAM_ADDR];
        end
    end

    int checks, errors;

    // Reference model state
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_hold [NP];
    int            m_ptr;
    bit            m_pv, m_pread, m_perr;
    int            m_pport;
    logic [DW-1:0] m_pdata;

    // Values sampled at the last checked negedge
    logic [NP-1:0] s_gnt, s_fgnt, s_rvalid, s_err;
    logic          s_cs;
    logic [4:0]    s_raddr;
    logic [DW-1:0] s_rdata0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_ptr = 0;
        m_pv = 0;
        for (int p = 0; p < NP; p++) m_hold[p] = '0;
    endtask

    function automatic int arb_rr(input logic [NP-1:0] r);
        for (int k = 0; k < NP; k++) if (r[(m_ptr + k) % NP]) return (m_ptr + k) % NP;
        return -1;
    endfunction

    function automatic int arb_fix(input logic [NP-1:0] r);
        for (int k = 0; k < NP; k++) if (r[k]) return k;
        return -1;
    endfunction

    // One clock: check at negedge against the model, advance the model at posedge.
    task automatic cycle();
        int g, gf, w;
        logic [NP-1:0] eg, erv, eer;
        logic [3:0] ewe;
        logic ecs;
        @(negedge CLK);
        if (!RSTb) m_reset();
        g  = arb_rr(REQ);
        gf = arb_fix(REQ);
        eg = '0; if (g >= 0) eg[g] = 1'b1;
        chk("gnt_rr", GNT, eg);
        eg = '0; if (gf >= 0) eg[gf] = 1'b1;
        chk("gnt_fix", f_gnt, eg);
        ecs = 1'b1; ewe = 4'hF; w = 0;
        if (g >= 0) begin
            w = int'(ADDR[g*AW+2 +: 6]);
            if (w < DEPTH && RSTb) begin
                ecs = 1'b0;
                if (WE[g]) ewe = ~BE[g*4 +: 4];
            end
        end
        chk("ram_csb", RAM_CSb, ecs);
        chk("ram_web", RAM_WEb, ewe);
        if (!ecs) begin
            chk("ram_addr", RAM_ADDR, w);
            chk("ram_wdata", RAM_WDATA, WDATA[g*DW +: DW]);
        end
        erv = '0; eer = '0;
        for (int p = 0; p < NP; p++) begin
            erv[p] = m_pv && m_pread && m_pport == p;
            eer[p] = m_pv && m_perr && m_pport == p;
        end
        chk("rvalid", RVALID, erv);
        chk("err", ERR, eer);
        for (int p = 0; p < NP; p++)
            chk($sformatf("rdata%0d", p), RDATA[p*DW +: DW], erv[p] ? m_pdata : m_hold[p]);
        s_gnt = GNT; s_fgnt = f_gnt; s_rvalid = RVALID; s_err = ERR;
        s_cs = RAM_CSb; s_raddr = RAM_ADDR; s_rdata0 = RDATA[DW-1:0];
        @(posedge CLK);
        if (RSTb) begin
            for (int p = 0; p < NP; p++) if (erv[p]) m_hold[p] = m_pdata;
            m_pv = 0;
            if (g >= 0) begin
                m_pv    = 1;
                m_pport = g;
                m_pread = !WE[g];
                m_perr  = (w >= DEPTH);
                m_pdata = m_perr ? '0 : m_mem[w];
                if (WE[g] && !m_perr)
                    for (int b = 0; b < 4; b++)
                        if (BE[g*4 + b]) m_mem[w][b*8 +: 8] = WDATA[g*DW + b*8 +: 8];
                m_ptr = (g + 1) % NP;
            end
        end
        #1;
    endtask

    task automatic clear_all();
        REQ = '0; WE = '0; ADDR = '0; WDATA = '0; BE = '0;
    endtask

    task automatic set_port(input int p, input bit rq, input bit we, input logic [7:0] a,
                            input logic [31:0] d, input logic [3:0] be);
        REQ[p] = rq; WE[p] = we; ADDR[p*AW +: AW] = a; WDATA[p*DW +: DW] = d;
        BE[p*4 +: 4] = be;
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt_fix;
        logic [3:0] gnt_rr;
    } vec_t;
    vec_t tbl [14];

    initial begin
        checks = 0; errors = 0;
        tbl[0]  = '{4'b0101, 4'b0001, 4'b0001};
        tbl[1]  = '{4'b0101, 4'b0001, 4'b0100};
        tbl[2]  = '{4'b0101, 4'b0001, 4'b0001};
        tbl[3]  = '{4'b0100, 4'b0100, 4'b0100};
        tbl[4]  = '{4'b1111, 4'b0001, 4'b1000};
        tbl[5]  = '{4'b1111, 4'b0001, 4'b0001};
        tbl[6]  = '{4'b1111, 4'b0001, 4'b0010};
        tbl[7]  = '{4'b1111, 4'b0001, 4'b0100};
        tbl[8]  = '{4'b1111, 4'b0001, 4'b1000};
        tbl[9]  = '{4'b1111, 4'b0001, 4'b0001};
        tbl[10] = '{4'b0000, 4'b0000, 4'b0000};
        tbl[11] = '{4'b0110, 4'b0010, 4'b0010};
        tbl[12] = '{4'b1010, 4'b0010, 4'b1000};
        tbl[13] = '{4'b0000, 4'b0000, 4'b0000};

        clear_all();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_reset();
        ram_clear = 1'b1;
        repeat (2) @(posedge CLK);
        #1 ram_clear = 1'b0;
        cycle();
        RSTb = 1'b1;
        cycle();
        cycle();

        // Grant sequences for both arbitration modes
        for (int i = 0; i < 14; i++) begin
            for (int p = 0; p < NP; p++) set_port(p, 1'b0, 1'b0, 8'((p + 1) * 4), '0, 4'hF);
            REQ = tbl[i].req;
            cycle();
            chk($sformatf("tbl%0d_fix", i), s_fgnt, tbl[i].gnt_fix);
            chk($sformatf("tbl%0d_rr", i), s_gnt, tbl[i].gnt_rr);
        end

        // Byte lanes
        clear_all();
        set_port(0, 1, 1, 8'h10, 32'h11223344, 4'hF);
        cycle();
        set_port(0, 1, 1, 8'h10, 32'hAABBCCDD, 4'b0101);
        cycle();
        set_port(0, 1, 0, 8'h10, '0, 4'h0);
        cycle();
        chk("lane_addr", s_raddr, 5'd4);
        clear_all();
        cycle();
        chk("lane_rdata", s_rdata0, 32'h11BB33DD);

        // Hold register isolation
        set_port(0, 1, 1, 8'h20, 32'hCAFEF00D, 4'hF);
        cycle();
        set_port(0, 1, 0, 8'h20, '0, 4'h0);
        cycle();
        clear_all();
        for (int i = 0; i < 10; i++) begin
            clear_all();
            set_port(1 + $urandom_range(0, 2), 1, 0, 8'($urandom_range(0, 31) * 4), '0, 4'hF);
            cycle();
        end
        clear_all();
        cycle();
        chk("hold_p0", s_rdata0, 32'hCAFEF00D);

        // Out-of-range read and write
        set_port(0, 1, 0, 8'h80, '0, 4'hF);
        cycle();
        chk("oor_csb", s_cs, 1'b1);
        clear_all();
        cycle();
        chk("oor_rvalid", s_rvalid, 4'b0001);
        chk("oor_err", s_err, 4'b0001);
        chk("oor_rdata", s_rdata0, 32'h0);
        set_port(1, 1, 1, 8'hFC, 32'h12345678, 4'hF);
        cycle();
        clear_all();
        cycle();
        chk("oor_wr_err", s_err, 4'b0010);
        chk("oor_wr_rvalid", s_rvalid, 4'b0000);

        // Reset while a read is pending, with traffic still requesting
        set_port(2, 1, 0, 8'h08, '0, 4'hF);
        cycle();
        RSTb = 1'b0;
        set_port(3, 1, 1, 8'h0C, 32'h55AA55AA, 4'hF);
        cycle();
        chk("rst_rvalid", s_rvalid, 4'b0000);
        chk("rst_csb", s_cs, 1'b1);
        clear_all();
        RSTb = 1'b1;
        cycle();
        chk("post_rst_rvalid", s_rvalid, 4'b0000);
        cycle();

        // Random traffic against the model
        repeat (400) begin
            for (int p = 0; p < NP; p++) begin
                logic [7:0] a;
                a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                : 8'($urandom_range(0, 127));
                set_port(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom(),
                         4'($urandom_range(0, 15)));
            end
            cycle();
        end
        clear_all();
        cycle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter_rr.md
Name: ram_arbiter_rr

Overview:
N-port arbiter that gives several controllers shared access to one single-port, byte-lane-writable synchronous RAM, one access per clock. It generalises the fixed two-port RAM front end in three ways: parametrised port count, data width and depth; selectable fixed-priority or round-robin arbitration; and an explicit request/grant/read-valid handshake with per-port held read data. It sits between the GPIO-control sequencers/host interface and the RAM macro wrapper.

Parameters:
NUM_PORTS, 4, number of requesting ports (2..8)
DATA_W, 32, data width in bits; multiple of 8
ADDR_W, 8, per-port byte address width
RAM_DEPTH, 32, number of RAM words; word index = ADDR[ADDR_W-1:BW] with BW = log2(DATA_W/8)
PRIO_MODE, 1, 0 = fixed priority (port 0 highest); 1 = round-robin

Ports:
CLK  in  1  clock
RSTb  in  1  asynchronous active-low reset
REQ  in  NUM_PORTS  per-port access request
WE  in  NUM_PORTS  per-port write enable (1 = write)
ADDR  in  NUM_PORTS*ADDR_W  per-port byte address, port p at [p*ADDR_W +: ADDR_W]
WDATA  in  NUM_PORTS*DATA_W  per-port write data
BE  in  NUM_PORTS*DATA_W/8  per-port byte enables, active-high
GNT  out  NUM_PORTS  one-hot grant, combinational
RVALID  out  NUM_PORTS  read data valid pulse
RDATA  out  NUM_PORTS*DATA_W  per-port read data
ERR  out  NUM_PORTS  out-of-range pulse, aligned with RVALID
RAM_CSb  out  1  RAM chip select, active-low
RAM_WEb  out  DATA_W/8  per-byte-lane write enable, active-low
RAM_ADDR  out  clog2(RAM_DEPTH)  RAM word address
RAM_WDATA  out  DATA_W  RAM write data
RAM_RDATA  in  DATA_W  RAM read data, valid one cycle after a read access

Behaviour:
- Reset is RSTb, asynchronous, active-low, on clock CLK. While reset is asserted: rr_ptr=0, pending read cleared, all hold registers 0. Outputs during reset: RVALID=0, ERR=0, RDATA=0, RAM_CSb=1, RAM_WEb all 1. GNT follows REQ combinationally using rr_ptr=0.
- Arbitration is combinational within the cycle.
  - PRIO_MODE=0: grant goes to the lowest-index requesting port.
  - PRIO_MODE=1: grant goes to the first requesting port at or after rr_ptr, wrapping from NUM_PORTS-1 to 0.
- At most one GNT bit is high. No REQ means GNT=0.
- Handshake: an access is accepted in a cycle where REQ[p]&GNT[p]=1. The requester must hold REQ/WE/ADDR/WDATA/BE stable until it is granted. It may drop REQ or present a new access in the cycle after acceptance.
- rr_ptr updates to (granted+1) mod NUM_PORTS on every acceptance only; it holds on idle cycles.
- RAM drive for an accepted, in-range access in the same cycle:
  - RAM_CSb=0, RAM_ADDR=word index, RAM_WDATA=WDATA[p].
  - RAM_WEb[i] = ~(WE[p] & BE[p][i]).
  - With no acceptance: RAM_CSb=1 and all RAM_WEb=1.
- Read latency: the accepted read in cycle N produces RVALID[p]=1 for exactly cycle N+1, with RDATA[p]=RAM_RDATA (pass-through). The hold register for p captures RAM_RDATA at the end of N+1.
- Outside RVALID, RDATA[p] holds the last value read by port p. Other ports' traffic never alters it.
- Throughput: back-to-back accesses from any ports are supported, one per cycle. A read in cycle N and an access in N+1 do not conflict.
- Writes produce no RVALID. A write with BE=0 is accepted and granted but modifies no lane.
- Out-of-range access (word index >= RAM_DEPTH): granted, RAM_CSb stays 1, no RAM write.
  - Read: RVALID=1 and ERR=1 in N+1, RDATA=0; the hold register captures 0.
  - Write: ERR=1 in N+1, RVALID=0.
- Reset asserted while a read is pending drops it; no RVALID after reset release.
- All state registers are on posedge CLK/negedge RSTb. No combinational path from RAM_RDATA to any internal state except the hold-register D input.

Test Plan:
- Reset: assert RSTb=0 mid-traffic → RAM_CSb=1, RAM_WEb=4'hF, all RVALID/ERR/RDATA=0. Release with no REQ → outputs unchanged.
- Fixed priority (PRIO_MODE=0): REQ=4'b0101 held with reads → GNT=0001 each cycle while port 0 requests. Drop REQ[0] → GNT=0100 next cycle.
- Round-robin (PRIO_MODE=1): REQ=4'hF continuously, all reads → GNT sequence 0001,0010,0100,1000,0001. Each port sees an RVALID pulse one cycle after its grant.
- Byte lanes: write 0x11223344 to byte addr 0x10 with BE=4'hF, then 0xAABBCCDD with BE=4'b0101, then read addr 0x10 → RAM_ADDR=4, RDATA=0x11BB33DD.
- Hold: port 0 reads 0xCAFEF00D, then ports 1–3 issue 10 reads of other data → port 0 RDATA stays 0xCAFEF00D; port 1 RDATA changes only on its RVALID cycles.
- Boundaries: read byte addr 0x80 (word 32) → RAM_CSb=1, next cycle RVALID=1, ERR=1, RDATA=0. Accept a read then pull RSTb low the next cycle → no RVALID after release.
